// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Level countdown for the bomb game. It latches the three BCD time digits
//   for the current level and decrements them once per second. It drives the
//   time display digits and flags detonation when the count reaches 000.
//
//   Optional feature macro: TIMER_PENALTY_EN
//     When defined, this adds the PENALTY_SEC parameter and the penalty input.
//     A penalty pulse in RUN/HOLD removes PENALTY_SEC seconds, saturating at 000.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   load         in   1  pulse: latch value_three/two/one as remaining time
//   value_three  in   4  BCD hundreds of allotted seconds
//   value_two    in   4  BCD tens
//   value_one    in   4  BCD units
//   start        in   1  begin counting from IDLE
//   hold         in   1  level: freeze countdown while high
//   penalty      in   1  pulse: wrong-wire penalty (TIMER_PENALTY_EN only)
//   digit_three  out  4  BCD hundreds of remaining seconds
//   digit_two    out  4  BCD tens
//   digit_one    out  4  BCD units
//   running      out  1  high in RUN
//   sec_tick     out  1  one-cycle pulse on every one-second decrement
//   expired      out  1  level, high in EXPIRED
//   expired_pls  out  1  one-cycle pulse on entry to EXPIRED
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int unsigned TICK_CYCLES = 50_000_000
`ifdef TIMER_PENALTY_EN
    ,
    parameter int unsigned PENALTY_SEC = 5
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    input  logic       start,
    input  logic       hold,
`ifdef TIMER_PENALTY_EN
    input  logic       penalty,
`endif
    output logic [3:0] digit_three,
    output logic [3:0] digit_two,
    output logic [3:0] digit_one,
    output logic       running,
    output logic       sec_tick,
    output logic       expired,
    output logic       expired_pls
);

    localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

`ifdef TIMER_PENALTY_EN
    // Penalty amounts in BCD, without and with a coincident one-second tick.
    localparam int unsigned PEN_P1 = PENALTY_SEC + 1;
    localparam logic [11:0] PEN_BCD    = {4'((PENALTY_SEC / 100) % 10),
                                          4'((PENALTY_SEC / 10) % 10),
                                          4'(PENALTY_SEC % 10)};
    localparam logic [11:0] PEN_P1_BCD = {4'((PEN_P1 / 100) % 10),
                                          4'((PEN_P1 / 10) % 10),
                                          4'(PEN_P1 % 10)};
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [11:0]   count;

    logic          active;
    logic          tick;
    logic [11:0]   dec_count;

    // Three-digit BCD subtraction a - b with digit borrow (a >= b assumed).
    function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
        logic [11:0] r;
        int          diff;
        int          br;
        r  = '0;
        br = 0;
        for (int i = 0; i < 3; i++) begin
            diff = int'(a[4*i +: 4]) - int'(b[4*i +: 4]) - br;
            if (diff < 0) begin
                diff = diff + 10;
                br   = 1;
            end else begin
                br = 0;
            end
            r[4*i +: 4] = 4'(diff);
        end
        return r;
    endfunction

    // Out-of-range BCD nibbles load as 9.
    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    assign digit_three = count[11:8];
    assign digit_two   = count[7:4];
    assign digit_one   = count[3:0];

    // The prescaler advances in RUN, or in HOLD on the cycle hold is released.
    always_comb begin
        active    = 1'b0;
        tick      = 1'b0;
        dec_count = bcd_sub(count, 12'h001);
        active    = ((state == S_RUN) || (state == S_HOLD)) && !hold;
        tick      = active && (presc == PRESC_LAST);
    end

`ifdef TIMER_PENALTY_EN
    logic [11:0] pen_amt;
    logic [11:0] pen_count;

    // Penalty result saturates at 000; valid BCD orders like binary.
    always_comb begin
        pen_amt   = tick ? PEN_P1_BCD : PEN_BCD;
        pen_count = (count <= pen_amt) ? 12'h000 : bcd_sub(count, pen_amt);
    end
`endif

    // Single-process state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            presc       <= '0;
            count       <= 12'h000;
            running     <= 1'b0;
            sec_tick    <= 1'b0;
            expired     <= 1'b0;
            expired_pls <= 1'b0;
        end else begin
            sec_tick    <= 1'b0;
            expired_pls <= 1'b0;
            if (load) begin
                count   <= {clamp9(value_three), clamp9(value_two), clamp9(value_one)};
                presc   <= '0;
                state   <= S_IDLE;
                running <= 1'b0;
                expired <= 1'b0;
            end
`ifdef TIMER_PENALTY_EN
            else if (penalty && ((state == S_RUN) || (state == S_HOLD))) begin
                sec_tick <= tick;
                if (active) begin
                    presc <= tick ? '0 : presc + PW'(1);
                end
                count <= pen_count;
                if (pen_count == 12'h000) begin
                    state       <= S_EXPIRED;
                    running     <= 1'b0;
                    expired     <= 1'b1;
                    expired_pls <= 1'b1;
                end else begin
                    state   <= hold ? S_HOLD : S_RUN;
                    running <= !hold;
                end
            end
`endif
            else if (hold && ((state == S_RUN) || (state == S_HOLD))) begin
                state   <= S_HOLD;
                running <= 1'b0;
            end else if (start && (state == S_IDLE)) begin
                if (count == 12'h000) begin
                    state       <= S_EXPIRED;
                    expired     <= 1'b1;
                    expired_pls <= 1'b1;
                end else begin
                    state   <= S_RUN;
                    running <= 1'b1;
                end
            end else if (active) begin
                if (tick) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                    count    <= dec_count;
                    if (dec_count == 12'h000) begin
                        state       <= S_EXPIRED;
                        running     <= 1'b0;
                        expired     <= 1'b1;
                        expired_pls <= 1'b1;
                    end else begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end else begin
                    presc   <= presc + PW'(1);
                    state   <= S_RUN;
                    running <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed bench for countdown_timer with TICK_CYCLES = 4. Inputs change and
//   outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] value_three;
    logic [3:0] value_two;
    logic [3:0] value_one;
    logic       start;
    logic       hold;
`ifdef TIMER_PENALTY_EN
    logic       penalty;
`endif
    logic [3:0] digit_three;
    logic [3:0] digit_two;
    logic [3:0] digit_one;
    logic       running;
    logic       sec_tick;
    logic       expired;
    logic       expired_pls;
    logic [11:0] digits;

    int tests;
    int failed;

    assign digits = {digit_three, digit_two, digit_one};

    countdown_timer #(
        .TICK_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_three(value_three),
        .value_two  (value_two),
        .value_one  (value_one),
        .start      (start),
        .hold       (hold),
`ifdef TIMER_PENALTY_EN
        .penalty    (penalty),
`endif
        .digit_three(digit_three),
        .digit_two  (digit_two),
        .digit_one  (digit_one),
        .running    (running),
        .sec_tick   (sec_tick),
        .expired    (expired),
        .expired_pls(expired_pls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_load(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1);
        value_three = d3;
        value_two   = d2;
        value_one   = d1;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int ticks;
        int pls;
        int bad_spacing;
        int hold_bad;

        tests       = 0;
        failed      = 0;
        rst_n       = 1'b0;
        load        = 1'b0;
        value_three = 4'd0;
        value_two   = 4'd0;
        value_one   = 4'd0;
        start       = 1'b0;
        hold        = 1'b0;
`ifdef TIMER_PENALTY_EN
        penalty     = 1'b0;
`endif
        step(2);
        check("reset_digits", 32'(digits), 32'h000);
        check("reset_flags", {28'd0, running, sec_tick, expired, expired_pls}, 32'h0);
        rst_n = 1'b1;
        step(1);

        // 1. Full countdown from 200.
        do_load(4'd2, 4'd0, 4'd0);
        check("t1_load_digits", 32'(digits), 32'h200);
        check("t1_load_idle", 32'(running), 32'd0);
        do_start();
        check("t1_running", 32'(running), 32'd1);
        ticks       = 0;
        pls         = 0;
        bad_spacing = 0;
        for (int i = 1; i <= 810; i++) begin
            @(negedge clk);
            if (sec_tick) begin
                ticks++;
                if (i % 4 != 0) bad_spacing++;
            end
            if (expired_pls) pls++;
            if (i == 4) begin
                check("t1_first_tick", 32'(sec_tick), 32'd1);
                check("t1_199", 32'(digits), 32'h199);
            end
            if (i == 799) check("t1_not_yet_expired", 32'(expired), 32'd0);
            if (i == 800) begin
                check("t1_000", 32'(digits), 32'h000);
                check("t1_expired", 32'(expired), 32'd1);
                check("t1_not_running", 32'(running), 32'd0);
            end
        end
        check("t1_tick_count", 32'(ticks), 32'd200);
        check("t1_tick_spacing", 32'(bad_spacing), 32'd0);
        check("t1_one_expired_pls", 32'(pls), 32'd1);

        // 2. BCD borrow from 010.
        do_load(4'd0, 4'd1, 4'd0);
        check("t2_load_clears_expired", 32'(expired), 32'd0);
        do_start();
        step(4);
        check("t2_tick1", 32'(sec_tick), 32'd1);
        check("t2_009", 32'(digits), 32'h009);
        step(4);
        check("t2_008", 32'(digits), 32'h008);

        // 3. Hold with prescaler at 2 freezes, then resumes from 2.
        step(2);
        hold     = 1'b1;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sec_tick || running || digits != 12'h008) hold_bad++;
        end
        check("t3_hold_frozen", 32'(hold_bad), 32'd0);
        hold = 1'b0;
        step(1);
        check("t3_resume_running", 32'(running), 32'd1);
        check("t3_no_early_tick", 32'(sec_tick), 32'd0);
        step(1);
        check("t3_tick_after_2", 32'(sec_tick), 32'd1);
        check("t3_007", 32'(digits), 32'h007);

        // 4. Load on the same edge as a tick wins and drops the tick.
        step(3);
        do_load(4'd0, 4'd5, 4'd5);
        check("t4_digits_055", 32'(digits), 32'h055);
        check("t4_no_tick", 32'(sec_tick), 32'd0);
        check("t4_not_running", 32'(running), 32'd0);
        step(8);
        check("t4_idle_holds_055", 32'(digits), 32'h055);
        do_load(4'hA, 4'hF, 4'd3);
        check("t4_clamp", 32'(digits), 32'h993);

        // 5. Start at 000 expires immediately; async reset mid-run.
        do_load(4'd0, 4'd0, 4'd0);
        do_start();
        check("t5_expired", 32'(expired), 32'd1);
        check("t5_expired_pls", 32'(expired_pls), 32'd1);
        step(1);
        check("t5_pls_one_cycle", 32'(expired_pls), 32'd0);
        do_start();
        check("t5_start_ignored", {29'd0, running, expired, expired_pls}, 32'h2);
        do_load(4'd1, 4'd2, 4'd3);
        do_start();
        step(2);
        check("t5_running_before_rst", 32'(running), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_digits", 32'(digits), 32'h000);
        check("t5_async_flags", {28'd0, running, sec_tick, expired, expired_pls}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        check("t5_idle_after_rst", {16'd0, digits, 3'd0, running}, {16'd0, 12'h000, 4'h0});

`ifdef TIMER_PENALTY_EN
        // 6. Penalty subtracts 5 with borrow and saturates into EXPIRED.
        do_load(4'd0, 4'd2, 4'd0);
        do_start();
        penalty = 1'b1;
        @(negedge clk);
        penalty = 1'b0;
        check("t6_015", 32'(digits), 32'h015);
        check("t6_still_running", 32'(running), 32'd1);
        do_load(4'd0, 4'd0, 4'd3);
        do_start();
        penalty = 1'b1;
        @(negedge clk);
        penalty = 1'b0;
        check("t6_sat_000", 32'(digits), 32'h000);
        check("t6_expired", {30'd0, expired, expired_pls}, 32'h3);
        check("t6_stopped", 32'(running), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
